fp_hazard_scoreboard: RTL and testbench
=======================================

# fp_hazard_scoreboard

Hazard-detection and scoreboard stage for the FP pipeline. It sits beside the forwarding unit, on the ID/EXE boundary, and covers the hazards forwarding cannot resolve:
- load-use;
- branch operands in ID that depend on a load;
- operands of the single, non-pipelined long-latency FP unit (divide/sqrt).

It produces the IF/ID stall and the ID/EXE bubble. It also tracks the in-flight long operation with a per-register busy mask and a countdown counter.

## Interface
- NUM_REGS, 32, architectural registers tracked (index width 5)
- LONG_LATENCY, 12, cycles from long-op issue to its writeback pulse (legal range 2..63)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_flush  in  1  ID instruction is being squashed this cycle (taken branch)
- id_rs1, id_rs2, id_rd  in  5 each  ID source and destination registers
- id_writes_rf  in  1  ID instruction writes the register file
- id_is_branch  in  1  ID instruction resolves a branch in ID
- id_is_long_op  in  1  ID instruction uses the long-latency FP unit
- exe_is_load, exe_rd  in  1, 5  EXE stage load indicator and destination
- mem_is_load, mem_rd  in  1, 5  MEM stage load indicator and destination
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_id_exe  out  1  insert NOP into ID/EXE
- long_busy  out  1  long unit occupied
- busy_mask  out  NUM_REGS  registers with a pending long-op write; bit 0 is always 0
- long_wb_valid, long_wb_rd  out  1, 5  one-cycle writeback pulse for the long-op result
- stall_count  out  32  stall-cycle counter (see Configuration)

## Operation
- Register 0 never causes a hazard and is never marked busy.
- Hazard terms are combinational and qualified by id_valid && !id_flush:
  - **LU (load-use):** exe_is_load, exe_rd != 0, and exe_rd equals id_rs1 or id_rs2.
  - **BR (branch-on-load):** id_is_branch, and a match of id_rs1/id_rs2 against either exe_rd with exe_is_load, or mem_rd with mem_is_load.
  - **SB (scoreboard):** busy_mask[id_rs1], busy_mask[id_rs2], or (id_writes_rf && busy_mask[id_rd]), the last being the WAW case.
  - **ST (structural):** id_is_long_op && long_busy.
- Stall and bubble:
  - stall_if_id = bubble_id_exe = LU | BR | SB | ST.
- Issue:
  - issue = id_valid && !id_flush && !stall_if_id.
  - On issue with id_is_long_op, the block sets busy_mask[id_rd] (when id_rd != 0), records the destination as long_wb_rd, and enters RUN.
- State machine:
  - IDLE: long_busy=0.
  - IDLE→RUN on a long-op issue; the counter loads LONG_LATENCY-1.
  - RUN: long_busy=1. The counter decrements each cycle.
  - At count 0, RUN asserts long_wb_valid for that cycle and returns to IDLE at the next edge, clearing the busy bit at that edge.
- Completion and new issue in the same cycle: the long unit stays occupied until the completion edge, so a long op in ID during the long_wb_valid cycle still stalls under ST. It issues the following cycle.
- A long op with id_rd == 0 still occupies the unit and still pulses long_wb_valid, with long_wb_rd = 0. No busy bit is set.
- The register file is write-first, so an instruction released after busy clears reads the new value.

## Timing
- All outputs are 0 on reset: busy_mask=0, state IDLE, counter 0, long_wb_valid=0, long_wb_rd=0, stall_count=0.
- Reset mid-RUN aborts the operation: no writeback pulse, busy cleared at that edge.
- stall_if_id and bubble_id_exe are combinational, with the same-cycle response to ID/EXE/MEM inputs.
- Long op issued in cycle t:
  - busy_mask and long_busy are visible from t+1;
  - long_wb_valid is high in cycle t+LONG_LATENCY;
  - busy clears at the end of that cycle;
  - a dependent instruction issues no earlier than t+LONG_LATENCY+1.
- Load-use: exactly one stall cycle.
- Branch-on-load:
  - two stall cycles if the load is in EXE;
  - one stall cycle if the load is in MEM.
- id_flush overrides all hazards: no stall and no issue.

## Configuration
- FP_HAZARD_STATS_EN:
  - **Defined:** stall_count increments by 1 on every cycle with stall_if_id=1, saturates at 32'hFFFF_FFFF, and clears on rst.
  - **Undefined:** the counter logic is absent and stall_count is tied to 0.

## Test plan
- Load-use: exe_is_load=1, exe_rd=5, ID reads rs1=5 → stall and bubble high for one cycle, then issue. Repeat with exe_rd=0 → no stall.
- Branch-on-load: load to r7 in EXE, ID branch reads rs2=7 → stall two cycles. Repeat with the load in MEM → stall one cycle.
- Long op, LONG_LATENCY=12: issue at t to r10 → busy_mask[10]=1 from t+1, long_wb_valid and long_wb_rd=10 at t+12. A reader of r10 stalls through t+12 and issues at t+13.
- WAW and structural: during RUN, a non-long op writing r10 stalls. A second long op to r3 stalls until the cycle after the pulse.
- Flush and reset: id_flush with a pending hazard → no stall. rst asserted at t+5 of a long op → busy_mask=0, long_busy=0, no pulse.
- With FP_HAZARD_STATS_EN defined: 3 stall cycles → stall_count=3. Without the macro → stall_count=0.

Source files
------------

// File: rtl/fp_hazard_scoreboard.sv
// rtl/fp_hazard_scoreboard.sv - ID/EXE hazard detection and long-latency FP scoreboard
// Optional stall statistics counter enabled by defining FP_HAZARD_STATS_EN.
module fp_hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int LONG_LATENCY = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic                        id_flush,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] id_rd,
    input  logic                        id_writes_rf,
    input  logic                        id_is_branch,
    input  logic                        id_is_long_op,
    input  logic                        exe_is_load,
    input  logic [$clog2(NUM_REGS)-1:0] exe_rd,
    input  logic                        mem_is_load,
    input  logic [$clog2(NUM_REGS)-1:0] mem_rd,
    output logic                        stall_if_id,
    output logic                        bubble_id_exe,
    output logic                        long_busy,
    output logic [NUM_REGS-1:0]         busy_mask,
    output logic                        long_wb_valid,
    output logic [$clog2(NUM_REGS)-1:0] long_wb_rd,
    output logic [31:0]                 stall_count
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = 6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       count, count_nxt;
    logic [NUM_REGS-1:0] mask_nxt;
    logic [RW-1:0]       wb_rd_nxt;
    logic                exe_hit, mem_hit;
    logic                hz_lu, hz_br, hz_sb, hz_st;
    logic                issue;

    assign long_busy     = (state == RUN);
    assign long_wb_valid = long_busy && (count == '0);

    always_comb begin
        exe_hit = exe_is_load && (exe_rd != '0) && ((exe_rd == id_rs1) || (exe_rd == id_rs2));
        mem_hit = mem_is_load && (mem_rd != '0) && ((mem_rd == id_rs1) || (mem_rd == id_rs2));
        hz_lu   = exe_hit;
        hz_br   = id_is_branch && (exe_hit || mem_hit);
        // Third term is the WAW case against the pending long-op destination.
        hz_sb   = busy_mask[id_rs1] || busy_mask[id_rs2] || (id_writes_rf && busy_mask[id_rd]);
        hz_st   = id_is_long_op && long_busy;
        stall_if_id   = id_valid && !id_flush && (hz_lu || hz_br || hz_sb || hz_st);
        bubble_id_exe = stall_if_id;
        issue         = id_valid && !id_flush && !stall_if_id;
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mask_nxt  = busy_mask;
        wb_rd_nxt = long_wb_rd;
        case (state)
            IDLE: begin
                if (issue && id_is_long_op) begin
                    state_nxt = RUN;
                    count_nxt = CW'(LONG_LATENCY - 1);
                    wb_rd_nxt = id_rd;
                    mask_nxt[id_rd] = 1'b1;
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_nxt = IDLE;
                    mask_nxt[long_wb_rd] = 1'b0;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        mask_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            busy_mask  <= '0;
            long_wb_rd <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            busy_mask  <= mask_nxt;
            long_wb_rd <= wb_rd_nxt;
        end
    end

`ifdef FP_HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall_if_id && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fp_hazard_scoreboard.sv
// tb/tb_fp_hazard_scoreboard.sv - directed self-checking bench for fp_hazard_scoreboard
module tb_fp_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 0, id_flush = 0, id_writes_rf = 0, id_is_branch = 0, id_is_long_op = 0;
    logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic        exe_is_load = 0, mem_is_load = 0;
    logic [4:0]  exe_rd = 0, mem_rd = 0;
    logic        stall_if_id, bubble_id_exe, long_busy, long_wb_valid;
    logic [31:0] busy_mask;
    logic [4:0]  long_wb_rd;
    logic [31:0] stall_count;

    int checks = 0;
    int fails  = 0;

    fp_hazard_scoreboard #(.NUM_REGS(32), .LONG_LATENCY(12)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_writes_rf(id_writes_rf), .id_is_branch(id_is_branch), .id_is_long_op(id_is_long_op),
        .exe_is_load(exe_is_load), .exe_rd(exe_rd),
        .mem_is_load(mem_is_load), .mem_rd(mem_rd),
        .stall_if_id(stall_if_id), .bubble_id_exe(bubble_id_exe),
        .long_busy(long_busy), .busy_mask(busy_mask),
        .long_wb_valid(long_wb_valid), .long_wb_rd(long_wb_rd),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_id(input logic v, input logic f, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wr, input logic br, input logic lng);
        id_valid = v; id_flush = f; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_writes_rf = wr; id_is_branch = br; id_is_long_op = lng;
    endtask

    task automatic set_ld(input logic el, input logic [4:0] erd, input logic ml, input logic [4:0] mrd);
        exe_is_load = el; exe_rd = erd; mem_is_load = ml; mem_rd = mrd;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        settle();
        checks++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL reset_mask: got %h want %h", busy_mask, 32'd0); end
        checks++; if (long_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", long_busy); end
        checks++; if (long_wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wbv: got %b want 0", long_wb_valid); end
        checks++; if (long_wb_rd !== 5'd0) begin fails++; $display("FAIL reset_wbrd: got %0d want 0", long_wb_rd); end
        checks++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_if_id); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 5, 2, 6, 1, 0, 0);
        set_ld(1, 5, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", stall_if_id); end
        checks++; if (bubble_id_exe !== 1'b1) begin fails++; $display("FAIL lu_bubble: got %b want 1", bubble_id_exe); end
        tick();
        set_ld(0, 0, 1, 5);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL lu_release: got %b want 0", stall_if_id); end
        tick();
        set_id(1, 0, 0, 0, 6, 1, 0, 0);
        set_ld(1, 0, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL lu_r0: got %b want 0", stall_if_id); end
        set_id(1, 0, 1, 9, 6, 1, 0, 0);
        set_ld(1, 9, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL lu_rs2: got %b want 1", stall_if_id); end
        set_id(0, 0, 1, 9, 6, 1, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL lu_invalid: got %b want 0", stall_if_id); end
        tick();
        do_reset();
    endtask

    task automatic test_branch();
        set_id(1, 0, 3, 7, 0, 0, 1, 0);
        set_ld(1, 7, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL br_exe_c1: got %b want 1", stall_if_id); end
        tick();
        set_ld(0, 0, 1, 7);
        settle();
        checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL br_exe_c2: got %b want 1", stall_if_id); end
        tick();
        set_ld(0, 0, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL br_exe_c3: got %b want 0", stall_if_id); end
        tick();
        set_ld(0, 0, 1, 7);
        settle();
        checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL br_mem_c1: got %b want 1", stall_if_id); end
        tick();
        set_ld(0, 0, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL br_mem_c2: got %b want 0", stall_if_id); end
        set_id(1, 0, 3, 7, 8, 1, 0, 0);
        set_ld(0, 0, 1, 7);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL nonbr_mem: got %b want 0", stall_if_id); end
        tick();
        do_reset();
    endtask

    task automatic test_long_op();
        set_id(1, 0, 1, 2, 10, 1, 0, 1);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL lo_issue: got %b want 0", stall_if_id); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            set_id(1, 0, 10, 0, 11, 1, 0, 0);
            settle();
            if (k == 1) begin
                checks++; if (busy_mask !== 32'h0000_0400) begin fails++; $display("FAIL lo_mask: got %h want %h", busy_mask, 32'h0000_0400); end
                checks++; if (long_busy !== 1'b1) begin fails++; $display("FAIL lo_busy: got %b want 1", long_busy); end
            end
            checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL lo_raw_stall c%0d: got %b want 1", k, stall_if_id); end
            checks++; if (long_wb_valid !== (k == 12)) begin fails++; $display("FAIL lo_wbv c%0d: got %b want %b", k, long_wb_valid, (k == 12)); end
            if (k == 12) begin
                checks++; if (long_wb_rd !== 5'd10) begin fails++; $display("FAIL lo_wbrd: got %0d want 10", long_wb_rd); end
            end
        end
        tick();
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL lo_release: got %b want 0", stall_if_id); end
        checks++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL lo_clear: got %h want 0", busy_mask); end
        checks++; if (long_busy !== 1'b0) begin fails++; $display("FAIL lo_idle: got %b want 0", long_busy); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_rd_zero();
        set_id(1, 0, 0, 0, 0, 1, 0, 1);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL r0_issue: got %b want 0", stall_if_id); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            set_id(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            if (k == 1) begin
                checks++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL r0_mask: got %h want 0", busy_mask); end
                checks++; if (long_busy !== 1'b1) begin fails++; $display("FAIL r0_busy: got %b want 1", long_busy); end
            end
            if (k == 12) begin
                checks++; if (long_wb_valid !== 1'b1) begin fails++; $display("FAIL r0_wbv: got %b want 1", long_wb_valid); end
                checks++; if (long_wb_rd !== 5'd0) begin fails++; $display("FAIL r0_wbrd: got %0d want 0", long_wb_rd); end
            end
        end
        tick();
        do_reset();
    endtask

    task automatic test_waw_struct();
        set_id(1, 0, 0, 0, 10, 1, 0, 1);
        settle();
        for (int k = 1; k <= 11; k++) begin
            tick();
            set_id(1, 0, 0, 0, 10, 1, 0, 0);
            settle();
            checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL waw_stall c%0d: got %b want 1", k, stall_if_id); end
        end
        tick();
        set_id(1, 0, 0, 0, 3, 1, 0, 1);
        settle();
        checks++; if (stall_if_id !== 1'b1) begin fails++; $display("FAIL st_pulse_stall: got %b want 1", stall_if_id); end
        checks++; if (long_wb_valid !== 1'b1) begin fails++; $display("FAIL st_pulse: got %b want 1", long_wb_valid); end
        tick();
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL st_issue: got %b want 0", stall_if_id); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (busy_mask !== 32'h0000_0008) begin fails++; $display("FAIL st_mask: got %h want %h", busy_mask, 32'h0000_0008); end
        checks++; if (long_wb_rd !== 5'd3) begin fails++; $display("FAIL st_wbrd: got %0d want 3", long_wb_rd); end
        do_reset();
    endtask

    task automatic test_flush();
        set_id(1, 0, 0, 0, 10, 1, 0, 1);
        settle();
        tick();
        set_id(1, 1, 10, 0, 11, 1, 0, 1);
        set_ld(1, 10, 0, 0);
        settle();
        checks++; if (stall_if_id !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", stall_if_id); end
        checks++; if (bubble_id_exe !== 1'b0) begin fails++; $display("FAIL flush_bubble: got %b want 0", bubble_id_exe); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        set_id(1, 0, 0, 0, 10, 1, 0, 1);
        settle();
        for (int k = 1; k <= 5; k++) begin
            tick();
            set_id(0, 0, 0, 0, 0, 0, 0, 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checks++; if (busy_mask !== 32'd0) begin fails++; $display("FAIL rmid_mask: got %h want 0", busy_mask); end
        checks++; if (long_busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", long_busy); end
        for (int k = 0; k < 12; k++) begin
            checks++; if (long_wb_valid !== 1'b0) begin fails++; $display("FAIL rmid_pulse c%0d: got %b want 0", k, long_wb_valid); end
            tick();
        end
    endtask

    task automatic test_stats();
        logic [31:0] exp_cnt;
        do_reset();
        set_id(1, 0, 5, 0, 6, 1, 0, 0);
        set_ld(1, 5, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        tick();
        settle();
`ifdef FP_HAZARD_STATS_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (stall_count !== exp_cnt) begin fails++; $display("FAIL stats_cnt: got %0d want %0d", stall_count, exp_cnt); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_long_op();
        test_rd_zero();
        test_waw_struct();
        test_flush();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
